rv_alu_mdu: RTL and testbench

Parametrised execute-stage arithmetic unit that replaces the single-cycle combinational ALU. It adds the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) through a radix-2 iterative datapath and carries a valid/ready handshake on both sides. It sits in Stage_EX between operand forwarding and the EX/MEM pipeline register. It stalls issue while a multi-cycle operation is in flight.

---
 rtl/rvx_ex_pkg.sv | 30 +++
 rtl/rv_muldiv_iter.sv | 135 +++++++++++++
 rtl/rv_alu_mdu.sv | 108 ++++++++++
 tb/tb_rv_alu_mdu.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rvx_ex_pkg.sv
// rtl/rvx_ex_pkg.sv - opcode, funct3 and FSM state constants for the EX-stage ALU/MDU
package rvx_ex_pkg;

  localparam int BUS_W = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/rv_muldiv_iter.sv
// rtl/rv_muldiv_iter.sv - radix-2 shift-add multiplier / restoring divider on operand magnitudes
module rv_muldiv_iter
  import rvx_ex_pkg::*;
#(
  parameter int XLEN = BUS_W,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

  logic [SHW-1:0]    cnt_q, cnt_d;
  logic              run_q, run_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   mc_q, mc_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, ovf_q, ovf_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;

  logic              is_div, a_sgn, b_sgn, a_neg, b_neg, q_bit;
  logic [XLEN-1:0]   a_mag, b_mag, quo_fix, rem_fix;
  logic [XLEN:0]     prod_sum, rem_sh, rem_diff;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt, prod_fix;

  always_comb begin
    is_div = funct3[2];
    a_sgn  = is_div ? ~funct3[0] : (funct3 == M_MULH || funct3 == M_MULHSU);
    b_sgn  = is_div ? ~funct3[0] : (funct3 == M_MULH);
    a_neg  = a_sgn & src_a[XLEN-1];
    b_neg  = b_sgn & src_b[XLEN-1];
    a_mag  = a_neg ? -src_a : src_a;
    b_mag  = b_neg ? -src_b : src_b;
  end

  // acc holds {hi, lo} of the product, or {remainder, dividend/quotient} when dividing
  always_comb begin
    prod_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({(XLEN+1){acc_q[0]}} & {1'b0, mc_q});
    mul_nxt  = {prod_sum, acc_q[XLEN-1:1]};
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, mc_q};
    q_bit    = ~rem_diff[XLEN];
    div_nxt  = {(q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], q_bit};
    acc_nxt  = op_q[2] ? div_nxt : mul_nxt;
  end

  // The result is formed from the final iteration so it is ready on the same edge
  always_comb begin
    prod_fix = neg_q ? -acc_nxt : acc_nxt;
    quo_fix  = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem_fix  = rneg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    if (dz_q) begin
      quo_fix = '1;
      rem_fix = dvd_q;
    end
    if (ovf_q) begin
      quo_fix = dvd_q;
      rem_fix = '0;
    end
    if (op_q[2])            result = op_q[1] ? rem_fix : quo_fix;
    else if (op_q == M_MUL) result = prod_fix[XLEN-1:0];
    else                    result = prod_fix[2*XLEN-1:XLEN];
    done = run_q & (cnt_q == CNT_LAST);
  end

  always_comb begin
    cnt_d  = cnt_q;
    run_d  = run_q;
    op_d   = op_q;
    mc_d   = mc_q;
    acc_d  = acc_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    ovf_d  = ovf_q;
    dvd_d  = dvd_q;
    if (flush) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      run_d  = 1'b1;
      cnt_d  = '0;
      op_d   = funct3;
      mc_d   = is_div ? b_mag : a_mag;
      acc_d  = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
      neg_d  = a_neg ^ b_neg;
      rneg_d = is_div & a_neg;
      dz_d   = is_div & (src_b == '0);
      ovf_d  = is_div & ~funct3[0] & (src_a == {1'b1, {(XLEN-1){1'b0}}}) & (&src_b);
      dvd_d  = src_a;
    end else if (run_q) begin
      acc_d = acc_nxt;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        run_d = 1'b0;
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      op_q   <= '0;
      mc_q   <= '0;
      acc_q  <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      ovf_q  <= 1'b0;
      dvd_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      op_q   <= op_d;
      mc_q   <= mc_d;
      acc_q  <= acc_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      ovf_q  <= ovf_d;
      dvd_q  <= dvd_d;
    end
  end

endmodule

// File: rtl/rv_alu_mdu.sv
// rtl/rv_alu_mdu.sv - EX-stage ALU plus iterative M-extension unit with valid/ready on both sides
module rv_alu_mdu
  import rvx_ex_pkg::*;
#(
  parameter int XLEN = BUS_W,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_isM,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_srcA,
  input  logic [XLEN-1:0] in_srcB,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] alu_res, mdu_result;
  logic [SHW-1:0]  shamt;
  logic            accept, mdu_done;

  assign in_ready   = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept     = in_valid & in_ready & ~flush;
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q == ST_CALC);
  assign out_result = result_q;
  assign shamt      = in_srcB[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (in_op)
      ALU_ADD:  alu_res = in_srcA + in_srcB;
      ALU_SUB:  alu_res = in_srcA - in_srcB;
      ALU_XOR:  alu_res = in_srcA ^ in_srcB;
      ALU_OR:   alu_res = in_srcA | in_srcB;
      ALU_AND:  alu_res = in_srcA & in_srcB;
      ALU_SLL:  alu_res = in_srcA << shamt;
      ALU_SRL:  alu_res = in_srcA >> shamt;
      ALU_SRA:  alu_res = $signed(in_srcA) >>> shamt;
      ALU_SLT:  alu_res[0] = $signed(in_srcA) < $signed(in_srcB);
      ALU_SLTU: alu_res[0] = in_srcA < in_srcB;
      default:  alu_res = '0;
    endcase
  end

  rv_muldiv_iter #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept & in_isM),
    .flush  (flush),
    .funct3 (in_op[2:0]),
    .src_a  (in_srcA),
    .src_b  (in_srcB),
    .done   (mdu_done),
    .result (mdu_result)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (in_isM) begin
              state_d = ST_CALC;
            end else begin
              state_d  = ST_DONE;
              result_d = alu_res;
            end
          end else if ((state_q == ST_DONE) && out_ready) begin
            state_d = ST_IDLE;
          end
        end
        ST_CALC: begin
          if (mdu_done) begin
            state_d  = ST_DONE;
            result_d = mdu_result;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_rv_alu_mdu.sv
// tb/tb_rv_alu_mdu.sv - directed-vector bench for rv_alu_mdu at XLEN=32 and XLEN=64
module tb_rv_alu_mdu;
  import rvx_ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0, in_isM = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [3:0]  in_op = '0;
  logic [31:0] in_srcA = '0, in_srcB = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_result;

  logic        w_in_valid = 1'b0, w_in_isM = 1'b0, w_flush = 1'b0, w_out_ready = 1'b1;
  logic [3:0]  w_in_op = '0;
  logic [63:0] w_in_srcA = '0, w_in_srcB = '0;
  logic        w_in_ready, w_out_valid, w_busy;
  logic [63:0] w_out_result;

  int n_checks = 0;
  int n_errors = 0;

  rv_alu_mdu #(.XLEN(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_isM(in_isM),
    .in_op(in_op), .in_srcA(in_srcA), .in_srcB(in_srcB), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .busy(busy)
  );

  rv_alu_mdu #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_isM(w_in_isM),
    .in_op(w_in_op), .in_srcA(w_in_srcA), .in_srcB(w_in_srcB), .flush(w_flush),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_result(w_out_result), .busy(w_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic is_m, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_isM = is_m; in_op = op; in_srcA = a; in_srcB = b;
    check_eq({tag, ".rdy"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    if (is_m) check_eq({tag, ".busy"}, 64'(busy), 64'd1);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, ".res"}, 64'(out_result), 64'(exp));
    check_eq({tag, ".lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic run_op64(input string tag, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp);
    int lat;
    @(negedge clk);
    w_in_valid = 1'b1; w_in_isM = 1'b1; w_in_op = op; w_in_srcA = a; w_in_srcB = b;
    @(negedge clk);
    w_in_valid = 1'b0;
    lat = 1;
    while (!w_out_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, ".res"}, w_out_result, exp);
    check_eq({tag, ".lat"}, 64'(lat), 64'd65);
  endtask

  initial begin
    logic seen;
    repeat (2) @(negedge clk);
    check_eq("rst.valid", 64'(out_valid), 64'd0);
    check_eq("rst.result", 64'(out_result), 64'd0);
    check_eq("rst.busy", 64'(busy), 64'd0);
    check_eq("rst.ready", 64'(in_ready), 64'd1);
    check_eq("rst.w_valid", 64'(w_out_valid), 64'd0);
    rst_n = 1'b1;

    run_op("add",  1'b0, ALU_ADD,  32'd5, 32'd7, 32'd12, 1);
    run_op("sub",  1'b0, ALU_SUB,  32'd5, 32'd7, 32'hFFFF_FFFE, 1);
    run_op("xor",  1'b0, ALU_XOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1);
    run_op("or",   1'b0, ALU_OR,   32'hF000_000F, 32'h0000_0F00, 32'hF000_0F0F, 1);
    run_op("and",  1'b0, ALU_AND,  32'hF0F0_FFFF, 32'h3C3C_00F0, 32'h3030_00F0, 1);
    run_op("sll",  1'b0, ALU_SLL,  32'd1, 32'h21, 32'd2, 1);
    run_op("srl",  1'b0, ALU_SRL,  32'h8000_0000, 32'd4, 32'h0800_0000, 1);
    run_op("sra",  1'b0, ALU_SRA,  32'h8000_0000, 32'd4, 32'hF800_0000, 1);
    run_op("slt",  1'b0, ALU_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_op("sltu", 1'b0, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run_op("undef", 1'b0, 4'b1001, 32'd5, 32'd7, 32'd0, 1);

    run_op("mulh",   1'b1, {1'b0, M_MULH},   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("mul",    1'b1, {1'b0, M_MUL},    32'h8000_0000, 32'h8000_0000, 32'h0, 33);
    run_op("mulhsu", 1'b1, {1'b0, M_MULHSU}, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("mulhu",  1'b1, {1'b0, M_MULHU},  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mul.neg", 1'b1, {1'b0, M_MUL},   32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("div",    1'b1, {1'b0, M_DIV},    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem",    1'b1, {1'b0, M_REM},    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu0",  1'b1, {1'b0, M_DIVU},   32'd7, 32'd0, 32'hFFFF_FFFF, 33);
    run_op("remu0",  1'b1, {1'b0, M_REMU},   32'd7, 32'd0, 32'd7, 33);
    run_op("div0",   1'b1, {1'b0, M_DIV},    32'd7, 32'd0, 32'hFFFF_FFFF, 33);
    run_op("rem0",   1'b1, {1'b0, M_REM},    32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 33);
    run_op("divovf", 1'b1, {1'b0, M_DIV},    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_op("removf", 1'b1, {1'b0, M_REM},    32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    run_op("divu",   1'b1, {1'b0, M_DIVU},   32'd100, 32'd7, 32'd14, 33);
    run_op("remu",   1'b1, {1'b0, M_REMU},   32'd100, 32'd7, 32'd2, 33);

    // Back-pressure: a second ADD is offered throughout the stall and must wait
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_isM = 1'b0; in_op = ALU_ADD; in_srcA = 32'd3; in_srcB = 32'd4;
    @(negedge clk);
    in_srcA = 32'd10; in_srcB = 32'd20;
    check_eq("bp.valid", 64'(out_valid), 64'd1);
    check_eq("bp.res", 64'(out_result), 64'd7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp.hold_res", 64'(out_result), 64'd7);
      check_eq("bp.hold_valid", 64'(out_valid), 64'd1);
      check_eq("bp.hold_rdy", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp.release_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("bp.next_valid", 64'(out_valid), 64'd1);
    check_eq("bp.next_res", 64'(out_result), 64'd30);

    // Flush at CALC cycle 12 of a DIV
    @(negedge clk);
    in_valid = 1'b1; in_isM = 1'b1; in_op = {1'b0, M_DIV}; in_srcA = 32'd100; in_srcB = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    check_eq("fl.busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("fl.busy", 64'(busy), 64'd0);
    check_eq("fl.valid", 64'(out_valid), 64'd0);
    check_eq("fl.idle_rdy", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq("fl.never_valid", 64'(seen), 64'd0);

    in_valid = 1'b1; in_isM = 1'b0; in_op = ALU_ADD; in_srcA = 32'd1; in_srcB = 32'd1; flush = 1'b1;
    @(negedge clk);
    check_eq("fl.alu_drop", 64'(out_valid), 64'd0);
    in_isM = 1'b1; in_op = {1'b0, M_MUL};
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check_eq("fl.m_drop_busy", 64'(busy), 64'd0);
    check_eq("fl.m_drop_valid", 64'(out_valid), 64'd0);
    run_op("fl.after", 1'b0, ALU_ADD, 32'd1, 32'd1, 32'd2, 1);

    // Asynchronous reset in the middle of a MUL
    @(negedge clk);
    in_valid = 1'b1; in_isM = 1'b1; in_op = {1'b0, M_MUL}; in_srcA = 32'd3; in_srcB = 32'd5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst.valid", 64'(out_valid), 64'd0);
    check_eq("arst.busy", 64'(busy), 64'd0);
    check_eq("arst.result", 64'(out_result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("arst.mul", 1'b1, {1'b0, M_MUL}, 32'd3, 32'd5, 32'd15, 33);

    run_op64("w.mulhu", {1'b0, M_MULHU}, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFE);
    run_op64("w.div", {1'b0, M_DIV}, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
